// File: rtl/seg_pkg.sv
// Purpose: shared constants for the 7-segment scan path: active-low glyph
//          patterns in {g,f,e,d,c,b,a} order and a width helper used to size
//          the slot counter and digit index.
// Contents: SEG_BLANK, SEG_DASH, SEG_0..SEG_9, clog2().
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  // Bits needed to hold 0..value-1; never less than 1 so single-state counters stay legal.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 1;
    while ((64'(1) << w) < 64'(value)) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Purpose: combinational BCD nibble to active-low 7-segment pattern.
// Ports:
//   i_nibble  in  4  BCD digit; 10..15 render as a dash
//   i_blank   in  1  force all segments off
//   o_seg_c   out 7  {g,f,e,d,c,b,a}, active-low (combinational)
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_blank,
  output logic [6:0] o_seg_c
);

  always_comb begin
    o_seg_c = SEG_DASH;
    if (i_blank) begin
      o_seg_c = SEG_BLANK;
    end else begin
      case (i_nibble)
        4'd0:    o_seg_c = SEG_0;
        4'd1:    o_seg_c = SEG_1;
        4'd2:    o_seg_c = SEG_2;
        4'd3:    o_seg_c = SEG_3;
        4'd4:    o_seg_c = SEG_4;
        4'd5:    o_seg_c = SEG_5;
        4'd6:    o_seg_c = SEG_6;
        4'd7:    o_seg_c = SEG_7;
        4'd8:    o_seg_c = SEG_8;
        4'd9:    o_seg_c = SEG_9;
        default: o_seg_c = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/bcd_seg_scan.sv
// Purpose: time-multiplexed common-anode 7-segment driver. Captures a packed
//          BCD word into a shadow register on bcd_vld, promotes the shadow to
//          the displayed copy only at frame wrap (no tearing), and scans one
//          digit per slot with an all-anodes-off guard at each slot start.
// Ports:
//   clk          in   1         system clock
//   rst_n        in   1         asynchronous active-low reset
//   bcd_in       in   4*DIGITS  packed BCD, nibble i = digit i (digit 0 rightmost)
//   dp_in        in   DIGITS    decimal point request per digit, 1 = lit
//   bcd_vld      in   1         capture strobe for bcd_in/dp_in
//   an           out  DIGITS    anode enables, active-low
//   seg          out  7         {g,f,e,d,c,b,a}, active-low
//   dp           out  1         decimal point, active-low
//   frame_start  out  1         one-cycle pulse after the digit index wraps to 0
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module bcd_seg_scan
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS    = 6,
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned SCAN_HZ   = 1_000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  bcd_vld,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_start
);

  localparam int unsigned DIV = CLK_HZ / SCAN_HZ;
  localparam int unsigned CW  = clog2(DIV);
  localparam int unsigned IW  = clog2(DIGITS);
  localparam int unsigned BW  = 4 * DIGITS;

  logic [CW-1:0]     r_cnt;
  logic [IW-1:0]     r_idx;
  logic [BW-1:0]     r_shadow_bcd;
  logic [DIGITS-1:0] r_shadow_dp;
  logic [BW-1:0]     r_disp_bcd;
  logic [DIGITS-1:0] r_disp_dp;
  logic [DIGITS-1:0] r_an;
  logic [6:0]        r_seg;
  logic              r_dp;
  logic              r_frame_start;

  logic              w_slot_end;
  logic              w_wrap;
  logic [3:0]        w_nibble;
  logic [DIGITS-1:0] w_blank_mask;
  logic [6:0]        w_seg;

  assign w_slot_end = (r_cnt == CW'(DIV - 1));
  assign w_wrap     = w_slot_end && (r_idx == IW'(DIGITS - 1));
  assign w_nibble   = 4'(r_disp_bcd >> {r_idx, 2'b00});

`ifdef LEADING_ZERO_BLANK_EN
  // Digit i is blank when it and every more-significant digit are zero; digit 0 never blanks.
  always_comb begin
    logic w_zero_run;
    w_blank_mask = '0;
    w_zero_run   = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      w_zero_run      = w_zero_run && (r_disp_bcd[4*i +: 4] == 4'd0);
      w_blank_mask[i] = w_zero_run;
    end
  end
`else
  assign w_blank_mask = '0;
`endif

  seg7_decode u_decode (
    .i_nibble (w_nibble),
    .i_blank  (w_blank_mask[r_idx]),
    .o_seg_c  (w_seg)
  );

  // Slot divider, digit index, shadow/display registers and registered pin drivers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_idx         <= '0;
      r_shadow_bcd  <= '0;
      r_shadow_dp   <= '0;
      r_disp_bcd    <= '0;
      r_disp_dp     <= '0;
      r_an          <= '1;
      r_seg         <= SEG_BLANK;
      r_dp          <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_cnt <= w_slot_end ? '0 : r_cnt + CW'(1);
      if (w_slot_end) begin
        r_idx <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);
      end
      if (bcd_vld) begin
        r_shadow_bcd <= bcd_in;
        r_shadow_dp  <= dp_in;
      end
      // Display takes the pre-edge shadow, so a coincident bcd_vld lands one frame later.
      if (w_wrap) begin
        r_disp_bcd <= r_shadow_bcd;
        r_disp_dp  <= r_shadow_dp;
      end
      // Anodes stay off during the guard interval to suppress ghosting.
      r_an          <= (r_cnt < CW'(BLANK_CYC)) ? '1 : ~(DIGITS'(1) << r_idx);
      r_seg         <= w_seg;
      r_dp          <= ~r_disp_dp[r_idx];
      r_frame_start <= w_wrap;
    end
  end

  assign an          = r_an;
  assign seg         = r_seg;
  assign dp          = r_dp;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Purpose: self-checking bench for bcd_seg_scan (DIGITS=6, DIV=10, BLANK_CYC=2).
//          A reference model derives every expected pin value from the elapsed
//          edge count since reset and the last captured BCD word.
// Build option: honours LEADING_ZERO_BLANK_EN in its reference model.
module tb_bcd_seg_scan;

  localparam int unsigned DIGITS    = 6;
  localparam int unsigned CLK_HZ    = 1000;
  localparam int unsigned SCAN_HZ   = 100;
  localparam int unsigned BLANK_CYC = 2;
  localparam int unsigned DIV       = CLK_HZ / SCAN_HZ;
  localparam int unsigned FRAME     = DIV * DIGITS;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] bcd_in = '0;
  logic [5:0]  dp_in = '0;
  logic        bcd_vld = 1'b0;
  logic [5:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  bcd_seg_scan #(
    .DIGITS    (DIGITS),
    .CLK_HZ    (CLK_HZ),
    .SCAN_HZ   (SCAN_HZ),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bcd_in      (bcd_in),
    .dp_in       (dp_in),
    .bcd_vld     (bcd_vld),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: edges since reset, captured word, displayed word.
  int          k;
  logic [23:0] m_sh_bcd, m_disp_bcd;
  logic [5:0]  m_sh_dp, m_disp_dp;
  logic [5:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic        exp_fs;
  int          fs_seen;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  function automatic logic [6:0] ref_seg(input logic [23:0] v, input int i);
    logic [23:0] upper;
    upper = v >> (4 * i);
`ifdef LEADING_ZERO_BLANK_EN
    if (i != 0 && upper == 24'd0) return 7'h7F;
`endif
    return glyph(upper[3:0]);
  endfunction

  task automatic model_reset();
    k = 0;
    m_sh_bcd = '0;
    m_sh_dp = '0;
    m_disp_bcd = '0;
    m_disp_dp = '0;
  endtask

  task automatic check_reset(input string tag);
    checks++;
    assert (an === 6'h3F) else begin errors++; $error("FAIL %s.an observed=%h expected=%h", tag, an, 6'h3F); end
    checks++;
    assert (seg === 7'h7F) else begin errors++; $error("FAIL %s.seg observed=%h expected=%h", tag, seg, 7'h7F); end
    checks++;
    assert (dp === 1'b1) else begin errors++; $error("FAIL %s.dp observed=%b expected=1", tag, dp); end
    checks++;
    assert (frame_start === 1'b0) else begin errors++; $error("FAIL %s.frame_start observed=%b expected=0", tag, frame_start); end
  endtask

  // One clock: drive inputs, advance the model across the edge, compare pins #1 later.
  task automatic tick(input logic vld, input logic [23:0] b, input logic [5:0] d);
    int cnt, idx;
    bcd_vld = vld;
    bcd_in  = b;
    dp_in   = d;
    @(posedge clk);
    cnt     = k % DIV;
    idx     = (k / DIV) % DIGITS;
    exp_an  = (cnt < BLANK_CYC) ? 6'h3F : 6'(~(6'd1 << idx));
    exp_seg = ref_seg(m_disp_bcd, idx);
    exp_dp  = ~m_disp_dp[idx];
    exp_fs  = ((k % FRAME) == FRAME - 1);
    if (exp_fs) begin
      m_disp_bcd = m_sh_bcd;
      m_disp_dp  = m_sh_dp;
    end
    if (vld) begin
      m_sh_bcd = b;
      m_sh_dp  = d;
    end
    k++;
    #1;
    checks++;
    assert (an === exp_an) else begin errors++; $error("FAIL scan.an k=%0d observed=%h expected=%h", k, an, exp_an); end
    checks++;
    assert (seg === exp_seg) else begin errors++; $error("FAIL scan.seg k=%0d observed=%h expected=%h", k, seg, exp_seg); end
    checks++;
    assert (dp === exp_dp) else begin errors++; $error("FAIL scan.dp k=%0d observed=%b expected=%b", k, dp, exp_dp); end
    checks++;
    assert (frame_start === exp_fs) else begin errors++; $error("FAIL scan.frame_start k=%0d observed=%b expected=%b", k, frame_start, exp_fs); end
    if (frame_start === 1'b1) fs_seen++;
  endtask

  initial begin
    model_reset();
    fs_seen = 0;

    // Reset state while held.
    #12;
    check_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Idle scan: two frames, frame_start every 60 cycles.
    repeat (120) tick(1'b0, 24'h0, 6'h0);
    checks++;
    assert (fs_seen == 2) else begin errors++; $error("FAIL frame_count observed=%0d expected=2", fs_seen); end

    // Ordered digits.
    tick(1'b1, 24'h123456, 6'h00);
    repeat (130) tick(1'b0, 24'h0, 6'h0);

    // Capture coincident with the wrap edge: one frame of lag.
    while ((k % FRAME) != FRAME - 1) tick(1'b0, 24'h0, 6'h0);
    tick(1'b1, 24'h000042, 6'h00);
    repeat (125) tick(1'b0, 24'h0, 6'h0);

    // Out-of-range nibble renders a dash; single decimal point.
    tick(1'b1, 24'h00A000, 6'b000100);
    repeat (125) tick(1'b0, 24'h0, 6'h0);

    // Leading-zero candidates.
    tick(1'b1, 24'h000705, 6'h00);
    repeat (125) tick(1'b0, 24'h0, 6'h0);
    tick(1'b1, 24'h000000, 6'h00);
    repeat (125) tick(1'b0, 24'h0, 6'h0);

    // Random captures, several per frame at times, inputs noisy while strobe is low.
    repeat (40) begin
      tick(1'b1, 24'($urandom), 6'($urandom));
      repeat ($urandom_range(0, 40)) tick(1'b0, 24'($urandom), 6'($urandom));
    end
    repeat (125) tick(1'b0, 24'h0, 6'h0);

    // Asynchronous reset mid-slot (idx=3, cnt=5).
    tick(1'b1, 24'h987654, 6'h3F);
    while ((k % FRAME) != 35) tick(1'b0, 24'h0, 6'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("midreset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (130) tick(1'b0, 24'h0, 6'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
